// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding and ID load-use stall generation.
// Keeps its own shadow copy of the in-flight instructions (entry 0 = EX,
// entry DEPTH = writeback) so no external pipeline-register fields are needed.
// Optional macro FWD_HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter
// output stall_cnt_o.
module fwd_hazard_unit #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned LOAD_STAGE = 2,
   localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   output logic [SEL_W-1:0]  ex_src1_sel_o,
   output logic [SEL_W-1:0]  ex_src2_sel_o,
   output logic              stall_o
`ifdef FWD_HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt_o
`endif
);

   // Shadow pipeline state; sources are only kept for the EX entry.
   logic [DEPTH:0]    ent_valid;
   logic [DEPTH:0]    ent_regwrite;
   logic [DEPTH:0]    ent_memread;
   logic [REG_AW-1:0] ent_rd [DEPTH+1];
   logic [REG_AW-1:0] ex_rs1;
   logic [REG_AW-1:0] ex_rs2;

   // Shift the shadow pipeline; EX takes the ID instruction or a bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ent_valid    <= '0;
         ent_regwrite <= '0;
         ent_memread  <= '0;
         for (int unsigned k = 0; k <= DEPTH; k++) begin
            ent_rd[k] <= '0;
         end
         ex_rs1 <= '0;
         ex_rs2 <= '0;
      end else begin
         for (int unsigned k = 1; k <= DEPTH; k++) begin
            ent_valid[k]    <= ent_valid[k-1];
            ent_regwrite[k] <= ent_regwrite[k-1];
            ent_memread[k]  <= ent_memread[k-1];
            ent_rd[k]       <= ent_rd[k-1];
         end
         if (stall_o || flush_i) begin
            ent_valid[0]    <= 1'b0;
            ent_regwrite[0] <= 1'b0;
            ent_memread[0]  <= 1'b0;
            ent_rd[0]       <= '0;
            ex_rs1          <= '0;
            ex_rs2          <= '0;
         end else begin
            ent_valid[0]    <= id_valid_i;
            ent_regwrite[0] <= id_regwrite_i;
            ent_memread[0]  <= id_memread_i;
            ent_rd[0]       <= id_rd_i;
            ex_rs1          <= id_rs1_i;
            ex_rs2          <= id_rs2_i;
         end
      end
   end

   // Forward select: youngest forwardable producer of each EX source wins.
   always_comb begin
      logic hit1;
      logic hit2;
      logic fwd_ok;
      ex_src1_sel_o = '0;
      ex_src2_sel_o = '0;
      hit1          = 1'b0;
      hit2          = 1'b0;
      fwd_ok        = 1'b0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         // Load data is not available before LOAD_STAGE.
         fwd_ok = ent_valid[k] && ent_regwrite[k] && (ent_rd[k] != '0)
                  && !(ent_memread[k] && (k < LOAD_STAGE));
         if (!hit1 && fwd_ok && (ent_rd[k] == ex_rs1)) begin
            ex_src1_sel_o = SEL_W'(k);
            hit1          = 1'b1;
         end
         if (!hit2 && fwd_ok && (ent_rd[k] == ex_rs2)) begin
            ex_src2_sel_o = SEL_W'(k);
            hit2          = 1'b1;
         end
      end
      if (!ent_valid[0] || rst_i) begin
         ex_src1_sel_o = '0;
         ex_src2_sel_o = '0;
      end
   end

   // Load-use stall: a load still too young to forward feeds an ID source.
   always_comb begin
      logic load_hit;
      load_hit = 1'b0;
      for (int unsigned j = 0; j + 1 < LOAD_STAGE; j++) begin
         if (ent_valid[j] && ent_memread[j] && ent_regwrite[j] && (ent_rd[j] != '0)
             && ((ent_rd[j] == id_rs1_i) || (ent_rd[j] == id_rs2_i))) begin
            load_hit = 1'b1;
         end
      end
      stall_o = id_valid_i && !flush_i && !rst_i && load_hit;
   end

`ifdef FWD_HAZARD_STALL_CNT_EN
   // Saturating count of stall cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks of fwd_hazard_unit against
// a history-queue model of the instructions that entered EX.
module tb_fwd_hazard_unit;

   localparam int REG_AW     = 5;
   localparam int DEPTH      = 2;
   localparam int LOAD_STAGE = 2;
   localparam int SEL_W      = $clog2(DEPTH + 1);

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_regwrite_i;
   logic              id_memread_i;
   logic              flush_i;
   logic [SEL_W-1:0]  ex_src1_sel_o;
   logic [SEL_W-1:0]  ex_src2_sel_o;
   logic              stall_o;
`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [31:0]       stall_cnt_o;
`endif

   fwd_hazard_unit #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .id_valid_i    (id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rd_i       (id_rd_i),
      .id_regwrite_i (id_regwrite_i),
      .id_memread_i  (id_memread_i),
      .flush_i       (flush_i),
      .ex_src1_sel_o (ex_src1_sel_o),
      .ex_src2_sel_o (ex_src2_sel_o),
      .stall_o       (stall_o)
`ifdef FWD_HAZARD_STALL_CNT_EN
      ,
      .stall_cnt_o   (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit mr;
      int rs1;
      int rs2;
   } ins_t;

   // hist[k] = instruction that entered EX k cycles ago (hist[0] is in EX now)
   ins_t        hist [DEPTH+1];
   logic [31:0] cnt_exp;
   int          errors = 0;
   int          checks = 0;
   bit          last_stall = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic bit produces(input ins_t e, input int r);
      return e.v && e.rw && (e.rd != 0) && (e.rd == r);
   endfunction

   function automatic int exp_sel(input int src);
      if (rst_i || !hist[0].v) return 0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (produces(hist[k], src) && !(hist[k].mr && (k < LOAD_STAGE))) return k;
      end
      return 0;
   endfunction

   function automatic bit exp_stall();
      if (rst_i || !id_valid_i || flush_i) return 1'b0;
      for (int j = 0; j < LOAD_STAGE - 1; j++) begin
         if (hist[j].mr && (produces(hist[j], int'(id_rs1_i)) || produces(hist[j], int'(id_rs2_i))))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                        input bit rw, input bit mr, input bit fl = 1'b0, input bit rs = 1'b0);
      id_valid_i    = v;
      id_rs1_i      = REG_AW'(rs1);
      id_rs2_i      = REG_AW'(rs2);
      id_rd_i       = REG_AW'(rd);
      id_regwrite_i = rw;
      id_memread_i  = mr;
      flush_i       = fl;
      rst_i         = rs;
      #1;
   endtask

   task automatic expect_now(input string tag, input int s1, input int s2, input int st);
      chk({tag, "/sel1"}, 32'(ex_src1_sel_o), 32'(s1));
      chk({tag, "/sel2"}, 32'(ex_src2_sel_o), 32'(s2));
      chk({tag, "/stall"}, 32'(stall_o), 32'(st));
   endtask

   // Check against the model, then advance one clock and update the model.
   task automatic cyc(input string tag);
      bit st;
      st = exp_stall();
      expect_now(tag, exp_sel(hist[0].rs1), exp_sel(hist[0].rs2), int'(st));
`ifdef FWD_HAZARD_STALL_CNT_EN
      chk({tag, "/cnt"}, stall_cnt_o, cnt_exp);
`endif
      @(posedge clk_i);
      if (rst_i) begin
         for (int k = 0; k <= DEPTH; k++) hist[k] = '{default: 0};
         cnt_exp = '0;
      end else begin
         for (int k = DEPTH; k >= 1; k--) hist[k] = hist[k-1];
         if (st || flush_i) hist[0] = '{default: 0};
         else hist[0] = '{id_valid_i, int'(id_rd_i), id_regwrite_i, id_memread_i,
                          int'(id_rs1_i), int'(id_rs2_i)};
         if (st && (cnt_exp != 32'hFFFF_FFFF)) cnt_exp = cnt_exp + 32'd1;
      end
      last_stall = st;
      #1;
   endtask

   task automatic nop(input string tag);
      drive(0, 0, 0, 0, 0, 0);
      cyc(tag);
   endtask

   task automatic drain();
      for (int i = 0; i <= DEPTH; i++) nop("drain");
   endtask

   initial begin
      for (int k = 0; k <= DEPTH; k++) hist[k] = '{default: 0};
      cnt_exp = '0;

      // Reset with random ID inputs
      drive(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1, 1, 0, 1);
      expect_now("rst0", 0, 0, 0);
      cyc("rst0m");
      drive(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1, 1, 0, 1);
      expect_now("rst1", 0, 0, 0);
      cyc("rst1m");
      drive(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1, 1);
      expect_now("post_rst", 0, 0, 0);
      cyc("post_rstm");
      drain();

      // Back-to-back dependency, both sources
      drive(1, 1, 2, 5, 1, 0); cyc("a1");
      drive(1, 5, 5, 6, 1, 0); cyc("a2");
      drive(0, 0, 0, 0, 0, 0);
      expect_now("b2b", 1, 1, 0);
      cyc("a3");
      drain();

      // Youngest producer wins
      drive(1, 1, 2, 5, 1, 0); cyc("y1");
      drive(1, 1, 2, 5, 1, 0); cyc("y2");
      drive(1, 5, 0, 7, 1, 0); cyc("y3");
      drive(0, 0, 0, 0, 0, 0);
      expect_now("youngest", 1, 0, 0);
      cyc("y4");
      drain();

      // Producer two stages back
      drive(1, 1, 2, 5, 1, 0); cyc("d1");
      drive(1, 1, 2, 9, 1, 0); cyc("d2");
      drive(1, 5, 0, 7, 1, 0); cyc("d3");
      drive(0, 0, 0, 0, 0, 0);
      expect_now("dist2", 2, 0, 0);
      cyc("d4");
      drain();

      // Load-use: one stall cycle, bubble, then forward from stage 2
      drive(1, 3, 0, 7, 1, 1); cyc("l1");
      drive(1, 7, 1, 8, 1, 0);
      expect_now("lu_stall", 0, 0, 1);
      cyc("l2");
      drive(1, 7, 1, 8, 1, 0);
      expect_now("lu_bubble", 0, 0, 0);
      cyc("l3");
      drive(0, 0, 0, 0, 0, 0);
      expect_now("lu_fwd", 2, 0, 0);
      cyc("l4");
      drain();

      // x0 never forwards or stalls
      drive(1, 1, 0, 0, 1, 0); cyc("z1");
      drive(1, 0, 0, 3, 1, 0); cyc("z2");
      drive(0, 0, 0, 0, 0, 0);
      expect_now("x0_fwd", 0, 0, 0);
      cyc("z3");
      drive(1, 1, 0, 0, 1, 1); cyc("z4");
      drive(1, 0, 0, 3, 1, 0);
      expect_now("x0_load", 0, 0, 0);
      cyc("z5");
      drain();

      // Flush beats stall
      drive(1, 3, 0, 7, 1, 1); cyc("f1");
      drive(1, 7, 7, 8, 1, 0, 1);
      expect_now("flush", 0, 0, 0);
      cyc("f2");
      drive(0, 0, 0, 0, 0, 0);
      expect_now("flush_next", 0, 0, 0);
      cyc("f3");
      drain();

      // Reset during a hazard
      drive(1, 3, 0, 7, 1, 1); cyc("r1");
      drive(1, 7, 0, 8, 1, 0, 0, 1);
      expect_now("rst_hz", 0, 0, 0);
      cyc("r2");
      drive(1, 7, 0, 8, 1, 0);
      expect_now("rst_after", 0, 0, 0);
      cyc("r3");

      // Random traffic; ID inputs are held while stalled
      for (int i = 0; i < 500; i++) begin
         if (last_stall) begin
            flush_i = ($urandom_range(0, 19) == 0);
            rst_i   = ($urandom_range(0, 49) == 0);
            #1;
         end else begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
         end
         cyc("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
